// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB slave memory: FSM states, word sizing
// and the byte-address to word-index decode.
package apb_mem_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] index;
  } dec_t;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int word_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Widths are normalised to 64 bits so one function serves any ADDR_WIDTH.
  function automatic dec_t decode(input logic [63:0] addr, input logic [63:0] base,
                                  input int unsigned shift, input int unsigned depth);
    logic [63:0] off;
    logic [63:0] mask;
    dec_t        r;
    off     = addr - base;
    mask    = (64'd1 << shift) - 64'd1;
    r.index = 32'(off >> shift);
    r.err   = (addr < base) || ((off & mask) != 64'd0) || ((off >> shift) >= 64'(depth));
    return r;
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB4 completer-side bus bundle; clock and reset travel as plain ports.
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_mem_array.sv
// Word storage with per-byte write enables, async clear and a combinational
// read port.
module apb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [IDX_W-1:0]        raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < NB; b++)
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  // Guard keeps non-power-of-two depths from indexing past the array.
  assign rdata_o = (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 slave memory: setup-edge decode/read, programmable wait states, write
// committed on the completing edge, error on range or alignment violations.
module apb_slave_mem
  import apb_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_slave_mem_if.slave   bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int SHIFT = word_shift(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  wr_q, wr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  dec_t                  dec;
  logic                  dec_err;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_unused;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  we;
  logic                  pready;

  assign dec        = decode(64'(bus.PADDR), 64'(BASE_ADDR), SHIFT, DEPTH);
  assign dec_err    = dec.err;
  assign dec_idx    = dec.index[IDX_W-1:0];
  assign dec_unused = ^dec.index;

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .we_i    (we),
    .waddr_i (idx_q),
    .wdata_i (bus.PWDATA),
    .wstrb_i (bus.PSTRB),
    .raddr_i (dec_idx),
    .rdata_o (rdata)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      prdata_q <= prdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    prdata_d = prdata_q;
    we       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          state_d  = S_ACCESS;
          cnt_d    = CNT_W'(WAIT_STATES);
          err_d    = dec_err;
          wr_d     = bus.PWRITE;
          idx_d    = dec_idx;
          prdata_d = dec_err ? '0 : rdata;
        end
      end
      S_ACCESS: begin
        // Dropping PSEL mid-transfer abandons it without touching memory.
        if (!bus.PSEL) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (bus.PENABLE) begin
          we      = wr_q && !err_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pready      = (state_q == S_ACCESS) && (cnt_q == '0);
  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pready && err_q;
  assign bus.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances (default, 2 wait states,
// BASE_ADDR=0x100) sharing one set of bus drivers, each with its own PSEL.
module tb_apb_slave_mem;

  logic        clk;
  logic        rst_n;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  int total  = 0;
  int passed = 0;

  apb_slave_mem_if if0 ();
  apb_slave_mem_if if1 ();
  apb_slave_mem_if if2 ();

  assign if0.PSEL = psel[0]; assign if0.PENABLE = penable; assign if0.PWRITE = pwrite;
  assign if0.PADDR = paddr;  assign if0.PWDATA = pwdata;   assign if0.PSTRB = pstrb;
  assign if1.PSEL = psel[1]; assign if1.PENABLE = penable; assign if1.PWRITE = pwrite;
  assign if1.PADDR = paddr;  assign if1.PWDATA = pwdata;   assign if1.PSTRB = pstrb;
  assign if2.PSEL = psel[2]; assign if2.PENABLE = penable; assign if2.PWRITE = pwrite;
  assign if2.PADDR = paddr;  assign if2.PWDATA = pwdata;   assign if2.PSTRB = pstrb;

  apb_slave_mem dut0 (.PCLK(clk), .PRESETn(rst_n), .bus(if0));
  apb_slave_mem #(.WAIT_STATES(2)) dut1 (.PCLK(clk), .PRESETn(rst_n), .bus(if1));
  apb_slave_mem #(.BASE_ADDR(32'h100)) dut2 (.PCLK(clk), .PRESETn(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rdy(input int d);
    case (d)
      0: return if0.PREADY;
      1: return if1.PREADY;
      default: return if2.PREADY;
    endcase
  endfunction

  function automatic logic serr(input int d);
    case (d)
      0: return if0.PSLVERR;
      1: return if1.PSLVERR;
      default: return if2.PSLVERR;
    endcase
  endfunction

  function automatic logic [31:0] rdat(input int d);
    case (d)
      0: return if0.PRDATA;
      1: return if1.PRDATA;
      default: return if2.PRDATA;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called #1 after a clock edge; leaves the bus idle #1 after the completing
  // edge, so a following call issues its setup back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err, output int waits,
                      output logic errlow);
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    waits  = 0;
    errlow = 1'b1;
    while (!rdy(d) && waits < 20) begin
      if (serr(d)) errlow = 1'b0;
      waits++;
      @(posedge clk); #1;
    end
    rd  = rdat(d);
    err = serr(d);
    if (!rdy(d)) waits = -1;
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
  endtask

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_wait;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] rd;
  logic        err;
  logic        errlow;
  int          waits;

  initial begin
    rst_n = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_prdata", if0.PRDATA, 32'h0);
    chk("rst_pready", {31'b0, if0.PREADY}, 32'h0);
    chk("rst_pslverr", {31'b0, if0.PSLVERR}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_pready", {31'b0, if0.PREADY}, 32'h0);

    // Two-wait-state write: storage must not change until the completing edge.
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h4; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("ws_pready", {31'b0, if1.PREADY}, {31'b0, c == 2});
      chk("ws_pslverr", {31'b0, if1.PSLVERR}, 32'h0);
      chk("ws_peek_old", dut1.u_mem.mem_q[1], 32'h0);
      if (c < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    chk("ws_peek_new", dut1.u_mem.mem_q[1], 32'hA5A5A5A5);

    //            d  wr    addr          wdata          strb   exp_rd         err   wait
    vecs.push_back('{0, 1'b0, 32'h00C, 32'h0,        4'h0, 32'h0,        1'b0, 0});
    vecs.push_back('{0, 1'b1, 32'h008, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 0});
    vecs.push_back('{0, 1'b0, 32'h008, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 0});
    vecs.push_back('{0, 1'b1, 32'h008, 32'h11223344, 4'h5, 32'h0,        1'b0, 0});
    vecs.push_back('{0, 1'b0, 32'h008, 32'h0,        4'h0, 32'hDE22BE44, 1'b0, 0});
    vecs.push_back('{0, 1'b1, 32'h000, 32'h12345678, 4'hF, 32'h0,        1'b0, 0});
    vecs.push_back('{0, 1'b1, 32'h040, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 0});
    vecs.push_back('{0, 1'b0, 32'h000, 32'h0,        4'h0, 32'h12345678, 1'b0, 0});
    vecs.push_back('{0, 1'b1, 32'h004, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 0});
    vecs.push_back('{0, 1'b0, 32'h004, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 0});
    vecs.push_back('{0, 1'b0, 32'h006, 32'h0,        4'h0, 32'h0,        1'b1, 0});
    vecs.push_back('{0, 1'b1, 32'h03C, 32'h0BADC0DE, 4'hF, 32'h0,        1'b0, 0});
    vecs.push_back('{0, 1'b0, 32'h03C, 32'h0,        4'h0, 32'h0BADC0DE, 1'b0, 0});
    vecs.push_back('{0, 1'b1, 32'h00C, 32'hAABBCCDD, 4'h0, 32'h0,        1'b0, 0});
    vecs.push_back('{0, 1'b0, 32'h00C, 32'h0,        4'h0, 32'h0,        1'b0, 0});
    vecs.push_back('{2, 1'b0, 32'h0FC, 32'h0,        4'h0, 32'h0,        1'b1, 0});
    vecs.push_back('{2, 1'b1, 32'h104, 32'h55AA55AA, 4'hF, 32'h0,        1'b0, 0});
    vecs.push_back('{2, 1'b0, 32'h104, 32'h0,        4'h0, 32'h55AA55AA, 1'b0, 0});
    vecs.push_back('{2, 1'b0, 32'h100, 32'h0,        4'h0, 32'h0,        1'b0, 0});
    vecs.push_back('{2, 1'b0, 32'h140, 32'h0,        4'h0, 32'h0,        1'b1, 0});
    vecs.push_back('{1, 1'b0, 32'h004, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0, 2});
    vecs.push_back('{1, 1'b1, 32'h044, 32'h01010101, 4'hF, 32'h0,        1'b1, 2});

    foreach (vecs[i]) begin
      xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
           rd, err, waits, errlow);
      chk($sformatf("v%0d_pslverr", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d_waits", i), waits, vecs[i].exp_wait);
      chk($sformatf("v%0d_errlow", i), {31'b0, errlow}, 32'h1);
      if (!vecs[i].wr) chk($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rd);
    end

    // Reset in the first wait cycle of a write: outputs clear at once and the
    // target word never receives the write.
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h4; pwdata = 32'h77777777; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("rst_mid_pre_prdata", if1.PRDATA, 32'hA5A5A5A5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_prdata", if1.PRDATA, 32'h0);
    chk("rst_mid_pready", {31'b0, if1.PREADY}, 32'h0);
    chk("rst_mid_pslverr", {31'b0, if1.PSLVERR}, 32'h0);
    chk("rst_mid_peek", dut1.u_mem.mem_q[1], 32'h0);
    psel = '0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, err, waits, errlow);
    chk("post_rst_prdata", rd, 32'h0);
    chk("post_rst_pslverr", {31'b0, err}, 32'h0);
    chk("post_rst_waits", waits, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
